// File: rtl/gate_lab_pkg.sv
// Shared definitions for the 2-input gate lab: op codes, FSM encoding, result
// record and the reference truth function used by the checker.
package gate_lab_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
  } result_t;

  function automatic logic gate_ref(input logic [2:0] op, input logic a, input logic b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_reserved(input logic [2:0] op);
    return op > OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the selected gate op; returns the value c should
// take for inputs a/b.
module gate_ref_model
  import gate_lab_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_exp
);

  assign o_exp = gate_ref(i_op, i_a, i_b);

endmodule

// File: rtl/gate_truth_table_driver.sv
// Sweeps {a,b} through 00,01,10,11 into a gate under test, holding each vector
// DWELL cycles, and checks c on the last dwell cycle against the selected op.
module gate_truth_table_driver
  import gate_lab_pkg::*;
#(
  parameter int DWELL = 100,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_sel,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  if (DWELL < 2 || DWELL > 65535 || (64'(1) << CNT_W) < 64'(DWELL)) begin : g_bad_param
    $error("gate_truth_table_driver: DWELL out of range or CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a;
  logic             r_b;
  result_t          r_res;

  logic       w_accept;
  logic       w_rsvd;
  logic       w_cmp;
  logic       w_last;
  logic       w_exp;
  logic       w_mis;
  logic [2:0] w_err_nxt;

  // start is only honoured between sweeps; busy sweeps ignore it
  assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_rsvd    = op_reserved(op_sel);
  assign w_cmp     = (r_state == S_DRIVE) && (r_cnt == CNT_LAST);
  assign w_last    = w_cmp && (r_idx == 2'd3);
  assign w_mis     = w_cmp && (c != w_exp);
  assign w_err_nxt = r_res.err_count + 3'(w_mis);

  gate_ref_model u_ref (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_exp (w_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_rsvd ? S_DONE : S_DRIVE;
      S_DRIVE: if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? (w_rsvd ? S_DONE : S_DRIVE) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_DRIVE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_a   <= 1'b0;
      r_b   <= 1'b0;
      r_res <= '0;
    end else if (w_accept) begin
      r_op  <= op_sel;
      r_idx <= '0;
      r_cnt <= '0;
      r_a   <= 1'b0;
      r_b   <= 1'b0;
      // a reserved op is reported as every vector failing, without driving the gate
      r_res <= w_rsvd ? '{pass: 1'b0, err_count: 3'd4, fail_vec: 4'hF} : '0;
    end else if (r_state == S_DRIVE) begin
      if (w_mis) begin
        r_res.fail_vec[r_idx] <= 1'b1;
        r_res.err_count       <= w_err_nxt;
      end
      if (w_last) begin
        r_res.pass <= (w_err_nxt == 3'd0);
        r_a        <= 1'b0;
        r_b        <= 1'b0;
      end else if (w_cmp) begin
        r_idx      <= r_idx + 2'd1;
        r_cnt      <= '0;
        {r_a, r_b} <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign pass      = r_res.pass;
  assign err_count = r_res.err_count;
  assign fail_vec  = r_res.fail_vec;

endmodule

// File: tb/tb_gate_truth_table_driver.sv
// Bench for gate_truth_table_driver (DWELL=4): table-driven sweeps with a result
// scoreboard, plus reserved-op, reset-abort and start re-pulse sequences.
module tb_gate_truth_table_driver;

  localparam int DWELL = 4;

  typedef struct {
    logic [1:0] mode;   // 0: OR gate, 1: c tied 0, 2: AND gate
    logic [2:0] op;
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op_sel = 3'd0;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] gut_mode = 2'd0;

  logic [2:0] m_op = 3'd0;
  logic       m_a = 1'b0, m_b = 1'b0, m_exp;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t last_res;
  vec_t tbl[8];
  logic [3:0] tt[6];

  always #5 clk = ~clk;

  assign c = (gut_mode == 2'd0) ? (a | b) : (gut_mode == 2'd1) ? 1'b0 : (a & b);

  gate_truth_table_driver #(.DWELL(DWELL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_ref_model u_model (.i_op(m_op), .i_a(m_a), .i_b(m_b), .o_exp(m_exp));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string nm, input res_t r);
    chk({nm, ".fail_vec"}, 32'(fail_vec), 32'(r.fail));
    chk({nm, ".err_count"}, 32'(err_count), 32'(r.err));
    chk({nm, ".pass"}, 32'(pass), 32'(r.pass));
  endtask

  // called at a negedge: request a sweep and record the expected outcome
  task automatic issue(input vec_t v);
    res_t r;
    gut_mode = v.mode;
    op_sel   = v.op;
    start    = 1'b1;
    r.fail = v.fail; r.err = v.err; r.pass = v.pass;
    exp_q.push_back(r);
  endtask

  // follows an accepted sweep to its done cycle; optional mid-sweep start pulse or reset
  task automatic follow(input int repulse, input int rst_cyc);
    int cyc = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      cyc++;
      if (done || cyc > 60) break;
      chk("sweep.a", 32'(a), 32'((cyc - 1) / DWELL >> 1));
      chk("sweep.b", 32'(b), 32'(((cyc - 1) / DWELL) & 1));
      chk("sweep.busy", 32'(busy), 32'd1);
      if (cyc == 1) chk_res("sweep.cleared", '{fail: 4'h0, err: 3'd0, pass: 1'b0});
      if (cyc == repulse) begin start = 1'b1; op_sel = 3'd0; end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.a", 32'(a), 32'd0);
        chk("abort.b", 32'(b), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_res("abort", '{fail: 4'h0, err: 3'd0, pass: 1'b0});
        void'(exp_q.pop_front());
        return;
      end
    end
    chk("sweep.latency", 32'(cyc), 32'(4 * DWELL + 1));
    chk("done.busy", 32'(busy), 32'd0);
    chk("done.ab", 32'({a, b}), 32'd0);
    if (exp_q.size() == 0) chk("scoreboard.empty", 32'd1, 32'd0);
    else begin
      last_res = exp_q.pop_front();
      chk_res("result", last_res);
    end
  endtask

  task automatic check_held();
    @(negedge clk);
    chk("held.done", 32'(done), 32'd0);
    chk("held.busy", 32'(busy), 32'd0);
    chk_res("held", last_res);
  endtask

  task automatic rsvd_sweep(input logic [2:0] op);
    vec_t v;
    v.mode = 2'd0; v.op = op; v.fail = 4'hF; v.err = 3'd4; v.pass = 1'b0;
    issue(v);
    @(negedge clk);
    start = 1'b0;
    chk("rsvd.done", 32'(done), 32'd1);
    chk("rsvd.busy", 32'(busy), 32'd0);
    chk("rsvd.ab", 32'({a, b}), 32'd0);
    last_res = exp_q.pop_front();
    chk_res("rsvd", last_res);
  endtask

  initial begin
    tt[0] = 4'b1110; tt[1] = 4'b1000; tt[2] = 4'b0110;
    tt[3] = 4'b0001; tt[4] = 4'b0111; tt[5] = 4'b1001;
    tbl[0] = '{mode: 2'd0, op: 3'd0, fail: 4'b0000, err: 3'd0, pass: 1'b1};
    tbl[1] = '{mode: 2'd0, op: 3'd1, fail: 4'b0110, err: 3'd2, pass: 1'b0};
    tbl[2] = '{mode: 2'd1, op: 3'd3, fail: 4'b0001, err: 3'd1, pass: 1'b0};
    tbl[3] = '{mode: 2'd0, op: 3'd2, fail: 4'b1000, err: 3'd1, pass: 1'b0};
    tbl[4] = '{mode: 2'd0, op: 3'd4, fail: 4'b1001, err: 3'd2, pass: 1'b0};
    tbl[5] = '{mode: 2'd0, op: 3'd5, fail: 4'b0111, err: 3'd3, pass: 1'b0};
    tbl[6] = '{mode: 2'd1, op: 3'd0, fail: 4'b1110, err: 3'd3, pass: 1'b0};
    tbl[7] = '{mode: 2'd2, op: 3'd4, fail: 4'b1111, err: 3'd4, pass: 1'b0};

    for (int op = 0; op < 6; op++)
      for (int ab = 0; ab < 4; ab++) begin
        m_op = 3'(op); m_a = ab[1]; m_b = ab[0];
        #1;
        chk($sformatf("ref_model.op%0d.ab%0d", op, ab), 32'(m_exp), 32'(tt[op][ab]));
      end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.ab", 32'({a, b}), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_res("reset", '{fail: 4'h0, err: 3'd0, pass: 1'b0});

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(tbl[i]);
      follow(0, 0);
      check_held();
    end

    @(negedge clk);
    rsvd_sweep(3'd6);
    check_held();
    rsvd_sweep(3'd7);
    check_held();

    // reset while idle with held failing results
    @(negedge clk);
    issue(tbl[1]);
    follow(0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_res("idle_rst", '{fail: 4'h0, err: 3'd0, pass: 1'b0});

    // reset during vector 2, then a clean sweep
    @(negedge clk);
    issue(tbl[1]);
    follow(0, 2 * DWELL + 2);
    @(negedge clk);
    issue(tbl[0]);
    follow(0, 0);
    check_held();

    // start mid-sweep is ignored; start in the done cycle chains a fresh sweep
    @(negedge clk);
    issue(tbl[1]);
    follow(6, 0);
    issue(tbl[0]);
    follow(0, 0);
    check_held();

    chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
